// File: rtl/bcd_tick_counter_if.sv
// bcd_tick_counter_if: control, display-select and status signals of the BCD tick counter
interface bcd_tick_counter_if #(parameter int NUM_DIGITS = 2, parameter int CW = 6);
  logic start;
  logic pause;
  logic clear;
  logic dir;
  logic [NUM_DIGITS-1:0] dig_sel_n;
  logic [3:0] num;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [CW-1:0] count;
  logic running;
  logic tick;
  logic wrap;
  modport master(output start, pause, clear, dir, dig_sel_n, input num, bcd, count, running, tick, wrap);
  modport slave(input start, pause, clear, dir, dig_sel_n, output num, bcd, count, running, tick, wrap);
endinterface

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: prescaled up/down wrapping counter kept in binary and BCD, with digit mux
module bcd_tick_counter #(
  parameter int TICK_CYCLES = 20000000,
  parameter int NUM_DIGITS = 2,
  parameter int MAX_COUNT = 32,
  parameter int CW = 6
) (
  input logic clk,
  input logic rst_n,
  bcd_tick_counter_if.slave bus
);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam int BW = 4*NUM_DIGITS;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  localparam logic [BW-1:0] MAX_BCD = to_bcd(MAX_COUNT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_COUNT);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES-1);
  state_t state, state_nx;
  logic [PW-1:0] pre;
  logic [CW-1:0] count;
  logic [BW-1:0] bcd, bcd_inc, bcd_dec;
  logic [3:0] num;
  logic wrap, tick, at_lim, cy, bw;
  assign tick = (state == RUN) && (pre == PRE_LAST);
  assign at_lim = bus.dir ? (count == '0) : (count == MAX_CNT);
  assign bus.num = num;
  assign bus.bcd = bcd;
  assign bus.count = count;
  assign bus.running = (state == RUN);
  assign bus.tick = tick;
  assign bus.wrap = wrap;
  // next state: clear dominates, and start beats a simultaneous pause
  always_comb
    state_nx = bus.clear ? IDLE :
               (state == IDLE && bus.start) ? RUN :
               (state == RUN && bus.pause && !bus.start) ? PAUSED :
               (state == PAUSED && (bus.start || bus.pause)) ? RUN : state;
  // ripple decimal carry/borrow so bcd tracks count without any division
  always_comb begin
    bcd_inc = bcd;
    bcd_dec = bcd;
    cy = 1'b1;
    bw = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cy) begin
        bcd_inc[4*i+:4] = (bcd[4*i+:4] == 4'd9) ? 4'd0 : bcd[4*i+:4] + 4'd1;
        cy = (bcd[4*i+:4] == 4'd9);
      end
      if (bw) begin
        bcd_dec[4*i+:4] = (bcd[4*i+:4] == 4'd0) ? 4'd9 : bcd[4*i+:4] - 4'd1;
        bw = (bcd[4*i+:4] == 4'd0);
      end
    end
  end
  // lowest-index active digit select wins; nothing selected blanks to F
  always_comb begin
    num = 4'hF;
    for (int i = NUM_DIGITS-1; i >= 0; i--)
      if (!bus.dig_sel_n[i]) num = bcd[4*i+:4];
  end
  // state, prescaler (held while paused), count/bcd step and wrap pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pre <= '0;
      count <= '0;
      bcd <= '0;
      wrap <= 1'b0;
    end else begin
      state <= state_nx;
      pre <= (bus.clear || state == IDLE || tick) ? '0 : (state == RUN) ? pre + PW'(1) : pre;
      wrap <= !bus.clear && tick && at_lim;
      if (bus.clear) begin
        count <= '0;
        bcd <= '0;
      end else if (tick) begin
        count <= at_lim ? (bus.dir ? MAX_CNT : '0) : bus.dir ? count - CW'(1) : count + CW'(1);
        bcd <= at_lim ? (bus.dir ? MAX_BCD : '0) : bus.dir ? bcd_dec : bcd_inc;
      end
    end
endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb_bcd_tick_counter: directed corner sequences plus random control checked against a count model
module tb_bcd_tick_counter;
  localparam int T = 4;
  localparam int ND = 2;
  localparam int MX = 32;
  localparam int CW = 6;
  typedef struct {logic [ND-1:0] ds; int num;} nv_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int m_mode, m_pre, m_cnt;
  bit m_wrap, m_ticked;
  nv_t tab[4];
  always #10 clk = ~clk;
  bcd_tick_counter_if #(.NUM_DIGITS(ND), .CW(CW)) bus();
  bcd_tick_counter #(.TICK_CYCLES(T), .NUM_DIGITS(ND), .MAX_COUNT(MX), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  function automatic int digit(input int v, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction
  function automatic int dec_bcd(input int v);
    int r;
    r = 0;
    for (int i = 0; i < ND; i++) r = r | (digit(v, i) << (4*i));
    return r;
  endfunction
  function automatic int exp_num(input int v, input logic [ND-1:0] ds);
    for (int i = 0; i < ND; i++) if (!ds[i]) return digit(v, i);
    return 15;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    m_mode = 0;
    m_pre = 0;
    m_cnt = 0;
    m_wrap = 0;
    m_ticked = 0;
  endtask
  task automatic check_all();
    chk("count", int'(bus.count), m_cnt);
    chk("bcd", int'(bus.bcd), dec_bcd(m_cnt));
    chk("running", int'(bus.running), int'(m_mode == 1));
    chk("tick", int'(bus.tick), int'(m_mode == 1 && m_pre == T-1));
    chk("wrap", int'(bus.wrap), int'(m_wrap));
    chk("num", int'(bus.num), exp_num(m_cnt, bus.dig_sel_n));
  endtask
  task automatic cyc(input bit s, input bit p, input bit c, input bit d, input logic [ND-1:0] ds);
    bit t;
    bus.start = s;
    bus.pause = p;
    bus.clear = c;
    bus.dir = d;
    bus.dig_sel_n = ds;
    #1;
    check_all();
    t = (m_mode == 1 && m_pre == T-1);
    @(posedge clk);
    m_ticked = t;
    if (c) model_reset();
    else begin
      m_wrap = t && (d ? m_cnt == 0 : m_cnt == MX);
      if (t) m_cnt = d ? (m_cnt + MX) % (MX + 1) : (m_cnt + 1) % (MX + 1);
      m_pre = (m_mode == 1) ? (t ? 0 : m_pre + 1) : (m_mode == 2) ? m_pre : 0;
      m_mode = (m_mode == 0 && s) ? 1 : (m_mode == 1 && p && !s) ? 2 : (m_mode == 2 && (s || p)) ? 1 : m_mode;
    end
    @(negedge clk);
    #1;
  endtask
  task automatic run_to(input int target, input bit d);
    int k;
    k = 0;
    while (m_cnt != target && k < 400) begin
      cyc(0, 0, 0, d, '1);
      k++;
    end
    chk("reach_count", int'(bus.count), target);
  endtask
  task automatic wait_tick(input bit d);
    int k;
    k = 0;
    do begin
      cyc(0, 0, 0, d, '1);
      k++;
    end while (!m_ticked && k < 2*T);
  endtask
  initial begin
    tab[0] = '{2'b10, 3};
    tab[1] = '{2'b01, 1};
    tab[2] = '{2'b11, 15};
    tab[3] = '{2'b00, 3};
    bus.start = 0;
    bus.pause = 0;
    bus.clear = 0;
    bus.dir = 0;
    bus.dig_sel_n = '1;
    model_reset();
    #1 rst_n = 1'b0;
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cyc(1, 0, 0, 0, '1);
    repeat (13*T) cyc(0, 0, 0, 0, '1);
    chk("count13", int'(bus.count), 13);
    chk("bcd13", int'(bus.bcd), 'h13);
    for (int i = 0; i < 4; i++) begin
      bus.dig_sel_n = tab[i].ds;
      #1;
      chk("num_tab", int'(bus.num), tab[i].num);
    end
    bus.dig_sel_n = '1;
    run_to(32, 0);
    wait_tick(0);
    chk("upwrap_count", int'(bus.count), 0);
    chk("upwrap_bcd", int'(bus.bcd), 0);
    chk("upwrap_wrap_hi", int'(bus.wrap), 1);
    cyc(0, 0, 0, 0, '1);
    chk("upwrap_wrap_lo", int'(bus.wrap), 0);
    wait_tick(1);
    chk("dnwrap_count", int'(bus.count), 32);
    chk("dnwrap_bcd", int'(bus.bcd), 'h32);
    chk("dnwrap_wrap", int'(bus.wrap), 1);
    wait_tick(1);
    chk("borrow_count", int'(bus.count), 31);
    chk("borrow_bcd", int'(bus.bcd), 'h31);
    cyc(0, 0, 0, 1, '1);
    cyc(0, 1, 0, 1, '1);
    repeat (20) cyc(0, 0, 0, $urandom_range(0, 1), '1);
    chk("paused_count", int'(bus.count), 31);
    chk("paused_running", int'(bus.running), 0);
    cyc(0, 1, 0, 0, '1);
    chk("resume_tick_lo", int'(bus.tick), 0);
    cyc(0, 0, 0, 0, '1);
    chk("resume_tick_hi", int'(bus.tick), 1);
    run_to(17, 0);
    cyc(1, 1, 1, 0, '1);
    chk("clr_count", int'(bus.count), 0);
    chk("clr_bcd", int'(bus.bcd), 0);
    chk("clr_running", int'(bus.running), 0);
    chk("clr_tick", int'(bus.tick), 0);
    cyc(1, 0, 0, 0, '1);
    cyc(0, 1, 0, 0, '1);
    chk("pause_running", int'(bus.running), 0);
    cyc(1, 1, 0, 0, '1);
    chk("sp_resume", int'(bus.running), 1);
    repeat (600)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
          $urandom_range(0, 1), ND'($urandom));
    cyc(1, 0, 0, 0, '1);
    cyc(1, 0, 0, 0, '1);
    repeat (3*T + 2) cyc(0, 0, 0, 0, '1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", int'(bus.count), 0);
    chk("arst_bcd", int'(bus.bcd), 0);
    chk("arst_running", int'(bus.running), 0);
    chk("arst_wrap", int'(bus.wrap), 0);
    chk("arst_tick", int'(bus.tick), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    repeat (20) cyc(0, 0, 0, $urandom_range(0, 1), '1);
    chk("idle_count", int'(bus.count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
